// File: rtl/nubus_slot_master_if.sv
// Signal bundle between the 68000-side decoder, the slot initiator and the slot card.
// The master modport is the initiator's view; the slave modport is the CPU/card side.
interface nubus_slot_master_if;
    logic [31:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic        cpu_as_n;
    logic        cpu_uds_n;
    logic        cpu_lds_n;
    logic        cpu_rw;
    logic        slot_hit;
    logic [15:0] cpu_din;
    logic        cpu_dtack_n;
    logic        cpu_berr_n;

    logic [31:0] addr;
    logic [15:0] data_out;
    logic [1:0]  uds_lds;
    logic        rw_n;
    logic        select;
    logic        ack_n;
    logic [15:0] data_in;
    logic        nmrq_n;
    logic        slot_irq;
    logic        busy;

    modport master (
        input  cpu_addr, cpu_dout, cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, slot_hit,
        output cpu_din, cpu_dtack_n, cpu_berr_n,
        output addr, data_out, uds_lds, rw_n, select,
        input  ack_n, data_in, nmrq_n,
        output slot_irq, busy
    );

    modport slave (
        output cpu_addr, cpu_dout, cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, slot_hit,
        input  cpu_din, cpu_dtack_n, cpu_berr_n,
        input  addr, data_out, uds_lds, rw_n, select,
        output ack_n, data_in, nmrq_n,
        input  slot_irq, busy
    );
endinterface

// File: rtl/nubus_slot_master.sv
// NuBus slot initiator: turns one 68000 slot-space cycle into a select/ack transaction
// and returns data, DTACK or bus error to the CPU. Also registers the card interrupt.
module nubus_slot_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    nubus_slot_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        DONE,
        ERROR,
        RECOVER
    } state_t;

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0] CNT_MAX  = 10'h3FF;

    state_t      state, state_nx;
    logic [9:0]  cnt, cnt_nx;
    logic        select_r, select_nx;
    logic        dtack_n_r, dtack_n_nx;
    logic        berr_n_r, berr_n_nx;
    logic [15:0] din_r, din_nx;
    logic [31:0] addr_r, addr_nx;
    logic [15:0] dout_r, dout_nx;
    logic [1:0]  ul_r, ul_nx;
    logic        rw_n_r, rw_n_nx;
    logic        busy_r, busy_nx;
    logic        irq_r;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        select_nx  = select_r;
        dtack_n_nx = dtack_n_r;
        berr_n_nx  = berr_n_r;
        din_nx     = din_r;
        addr_nx    = addr_r;
        dout_nx    = dout_r;
        ul_nx      = ul_r;
        rw_n_nx    = rw_n_r;

        case (state)
            IDLE: begin
                select_nx = 1'b0;
                // A stale acknowledge from the previous card cycle blocks the start.
                if (!bus.cpu_as_n && bus.slot_hit && bus.ack_n) begin
                    addr_nx   = bus.cpu_addr;
                    dout_nx   = bus.cpu_dout;
                    rw_n_nx   = bus.cpu_rw;
                    ul_nx     = {~bus.cpu_uds_n, ~bus.cpu_lds_n};
                    select_nx = 1'b1;
                    cnt_nx    = 10'd0;
                    state_nx  = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                if (bus.cpu_as_n) begin
                    select_nx = 1'b0;
                    state_nx  = RECOVER;
                end else if (!bus.ack_n) begin
                    if (rw_n_r) begin
                        din_nx = bus.data_in;
                    end
                    select_nx  = 1'b0;
                    dtack_n_nx = 1'b0;
                    state_nx   = DONE;
                end else if (cnt == CNT_LAST) begin
                    select_nx = 1'b0;
                    berr_n_nx = 1'b0;
                    state_nx  = ERROR;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + 10'd1;
                end
            end

            DONE, ERROR: begin
                select_nx = 1'b0;
                if (bus.cpu_as_n) begin
                    dtack_n_nx = 1'b1;
                    berr_n_nx  = 1'b1;
                    state_nx   = RECOVER;
                end
            end

            RECOVER: begin
                select_nx = 1'b0;
                if (bus.ack_n) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                select_nx = 1'b0;
                state_nx  = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 10'd0;
            select_r  <= 1'b0;
            dtack_n_r <= 1'b1;
            berr_n_r  <= 1'b1;
            din_r     <= 16'd0;
            addr_r    <= 32'd0;
            dout_r    <= 16'd0;
            ul_r      <= 2'b00;
            rw_n_r    <= 1'b1;
            busy_r    <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            select_r  <= select_nx;
            dtack_n_r <= dtack_n_nx;
            berr_n_r  <= berr_n_nx;
            din_r     <= din_nx;
            addr_r    <= addr_nx;
            dout_r    <= dout_nx;
            ul_r      <= ul_nx;
            rw_n_r    <= rw_n_nx;
            busy_r    <= busy_nx;
            irq_r     <= ~bus.nmrq_n;
        end
    end

    assign bus.cpu_din     = din_r;
    assign bus.cpu_dtack_n = dtack_n_r;
    assign bus.cpu_berr_n  = berr_n_r;
    assign bus.addr        = addr_r;
    assign bus.data_out    = dout_r;
    assign bus.uds_lds     = ul_r;
    assign bus.rw_n        = rw_n_r;
    assign bus.select      = select_r;
    assign bus.slot_irq    = irq_r;
    assign bus.busy        = busy_r;

endmodule
